hour_counter: RTL and testbench

- Hour stage of the digital clock; sits directly downstream of the minute counter.
- Consumes the minute stage's wrap pulse and counts 0..23.
- Supports direct load and a manual set mode with inc/dec.
- Drives the shared databus when enabled and emits a day-carry pulse to the date/calendar stage.

---
 rtl/hour_counter_if.sv | 40 ++++
 rtl/hour_counter.sv | 112 +++++++++++
 tb/tb_hour_counter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hour_counter_if.sv
// rtl/hour_counter_if.sv - hour stage signal bundle: minute tick, load/set controls, hour/BCD/databus outputs
// HOUR_12H_EN adds the pm flag to the bundle.
interface hour_counter_if #(
  parameter int WIDTH = 5
);
  logic             min_tick;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             enable;
  logic             set_mode;
  logic             inc;
  logic             dec;
  logic [WIDTH-1:0] hour;
  logic [1:0]       hour_tens;
  logic [3:0]       hour_ones;
  logic [WIDTH-1:0] databus;
  logic             day_carry;
  logic             load_err;
`ifdef HOUR_12H_EN
  logic             pm;

  modport master (
    output min_tick, load, data, enable, set_mode, inc, dec,
    input  hour, hour_tens, hour_ones, databus, day_carry, load_err, pm
  );
  modport slave (
    input  min_tick, load, data, enable, set_mode, inc, dec,
    output hour, hour_tens, hour_ones, databus, day_carry, load_err, pm
  );
`else
  modport master (
    output min_tick, load, data, enable, set_mode, inc, dec,
    input  hour, hour_tens, hour_ones, databus, day_carry, load_err
  );
  modport slave (
    input  min_tick, load, data, enable, set_mode, inc, dec,
    output hour, hour_tens, hour_ones, databus, day_carry, load_err
  );
`endif
endinterface

// File: rtl/hour_counter.sv
// rtl/hour_counter.sv - hour stage: counts minute wraps 0..MAX_HOUR, load, manual set, BCD, databus, day carry
// Define HOUR_12H_EN for 12-hour BCD display and the pm output.
module hour_counter #(
  parameter int MAX_HOUR = 23,
  parameter int WIDTH    = 5
) (
  input  logic         clk,
  input  logic         clear,
  hour_counter_if.slave bus
);

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_HOUR);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hour_q, hour_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] disp;
  logic [WIDTH-1:0] ones_w;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= RUN;
      hour_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // The action on an edge follows state_q; the new mode only applies from the next edge.
  always_comb begin
    state_d = bus.set_mode ? SET : RUN;
    hour_d  = hour_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (bus.data <= MAX_V) begin
        hour_d = bus.data;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (bus.min_tick) begin
            if (hour_q == MAX_V) begin
              hour_d  = '0;
              carry_d = 1'b1;
            end else begin
              hour_d = hour_q + ONE_V;
            end
          end
        end
        SET: begin
          if (bus.inc && !bus.dec) begin
            hour_d = (hour_q == MAX_V) ? '0 : hour_q + ONE_V;
          end else if (bus.dec && !bus.inc) begin
            hour_d = (hour_q == '0) ? MAX_V : hour_q - ONE_V;
          end
        end
        default: hour_d = hour_q;
      endcase
    end
  end

`ifdef HOUR_12H_EN
  always_comb begin
    if (hour_q == '0) begin
      disp = WIDTH'(12);
    end else if (hour_q > WIDTH'(12)) begin
      disp = hour_q - WIDTH'(12);
    end else begin
      disp = hour_q;
    end
  end

  assign bus.pm = (hour_q >= WIDTH'(12));
`else
  assign disp = hour_q;
`endif

  always_comb begin
    if (disp >= WIDTH'(20)) begin
      bus.hour_tens = 2'd2;
      ones_w        = disp - WIDTH'(20);
    end else if (disp >= WIDTH'(10)) begin
      bus.hour_tens = 2'd1;
      ones_w        = disp - WIDTH'(10);
    end else begin
      bus.hour_tens = 2'd0;
      ones_w        = disp;
    end
  end

  assign bus.hour_ones = 4'(ones_w);
  assign bus.hour      = hour_q;
  assign bus.databus   = bus.enable ? hour_q : '0;
  assign bus.day_carry = carry_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_hour_counter.sv
// tb/tb_hour_counter.sv - self-checking bench for hour_counter: vector table, corner sequences, random vs model
// Define HOUR_12H_EN to check the 12-hour display build.
module tb_hour_counter;

  logic clk;
  logic clear;
  int   passed;
  int   total;

  int m_hour;
  int m_set;
  int m_carry;
  int m_err;

  hour_counter_if #(.WIDTH(5)) bus ();

  hour_counter #(.MAX_HOUR(23), .WIDTH(5)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int clr;
    int ld;
    int d;
    int tk;
    int sm;
    int in;
    int de;
    int en;
    int eh;
    int ec;
    int ee;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void bcd_exp(input int h, output int t, output int o);
    int disp;
`ifdef HOUR_12H_EN
    disp = (h % 12 == 0) ? 12 : h % 12;
`else
    disp = h;
`endif
    t = disp / 10;
    o = disp % 10;
  endfunction

  // Reference: one clock edge described directly by the counting rules.
  task automatic model_step(input int clr, input int ld, input int d, input int tk,
                            input int sm, input int in, input int de);
    m_carry = 0;
    m_err   = 0;
    if (clr != 0) begin
      m_hour = 0;
      m_set  = 0;
    end else begin
      if (ld != 0) begin
        if (d <= 23) m_hour = d;
        else m_err = 1;
      end else if (m_set == 0) begin
        if (tk != 0) begin
          m_hour  = (m_hour + 1) % 24;
          m_carry = (m_hour == 0) ? 1 : 0;
        end
      end else if ((in != 0) != (de != 0)) begin
        m_hour = (m_hour + ((in != 0) ? 1 : 23)) % 24;
      end
      m_set = sm;
    end
  endtask

  task automatic drive(input int clr, input int ld, input int d, input int tk,
                       input int sm, input int in, input int de, input int en);
    clear        = (clr != 0);
    bus.load     = (ld != 0);
    bus.data     = 5'(d);
    bus.min_tick = (tk != 0);
    bus.set_mode = (sm != 0);
    bus.inc      = (in != 0);
    bus.dec      = (de != 0);
    bus.enable   = (en != 0);
    model_step(clr, ld, d, tk, sm, in, de);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int t;
    int o;
    bcd_exp(m_hour, t, o);
    check({tag, " hour"}, int'(bus.hour), m_hour);
    check({tag, " day_carry"}, int'(bus.day_carry), m_carry);
    check({tag, " load_err"}, int'(bus.load_err), m_err);
    check({tag, " databus"}, int'(bus.databus), bus.enable ? m_hour : 0);
    check({tag, " tens"}, int'(bus.hour_tens), t);
    check({tag, " ones"}, int'(bus.hour_ones), o);
`ifdef HOUR_12H_EN
    check({tag, " pm"}, int'(bus.pm), (m_hour >= 12) ? 1 : 0);
`endif
  endtask

  initial begin
    int t;
    int o;
    int sm;
    passed = 0;
    total  = 0;
    m_hour = 0;
    m_set  = 0;

    //            clr ld d  tk sm in de en  hour carry err
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 1, 22, 0, 0, 0, 0, 0, 22, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 22, 0, 0};
    vecs[3]  = '{0, 1, 23, 0, 0, 0, 0, 0, 23, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    vecs[6]  = '{0, 1, 5, 0, 0, 0, 0, 0,  5, 0, 0};
    vecs[7]  = '{0, 1, 27, 0, 0, 0, 0, 1, 5, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,  5, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 1, 0, 1, 0, 23, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 1, 1, 0,  0, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0};
    vecs[16] = '{0, 1, 23, 0, 0, 0, 0, 0, 23, 0, 0};
    vecs[17] = '{0, 1, 7, 1, 0, 0, 0, 0,  7, 0, 0};
    vecs[18] = '{0, 1, 23, 0, 1, 0, 0, 0, 23, 0, 0};
    vecs[19] = '{0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 1, 0, 1, 0, 23, 0, 0};
    vecs[21] = '{1, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0};
    vecs[22] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0};
    vecs[23] = '{0, 1, 23, 0, 0, 0, 0, 0, 23, 0, 0};
    vecs[24] = '{1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0};
    vecs[25] = '{0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0};
    vecs[26] = '{0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0};

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset hour", int'(bus.hour), 0);
    check("reset day_carry", int'(bus.day_carry), 0);
    check("reset load_err", int'(bus.load_err), 0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].d, vecs[i].tk,
            vecs[i].sm, vecs[i].in, vecs[i].de, vecs[i].en);
      check($sformatf("vec%0d hour", i), int'(bus.hour), vecs[i].eh);
      check($sformatf("vec%0d day_carry", i), int'(bus.day_carry), vecs[i].ec);
      check($sformatf("vec%0d load_err", i), int'(bus.load_err), vecs[i].ee);
      check($sformatf("vec%0d databus", i), int'(bus.databus),
            (vecs[i].en != 0) ? vecs[i].eh : 0);
    end

    // databus follows enable with no clock edge in between
    drive(0, 1, 22, 0, 0, 0, 0, 0);
    bus.enable = 1'b1;
    #1;
    check("comb databus on", int'(bus.databus), 22);
    bus.enable = 1'b0;
    #1;
    check("comb databus off", int'(bus.databus), 0);

    // day_carry is exactly one cycle wide after 23->0
    drive(0, 1, 23, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    check("rollover hour", int'(bus.hour), 0);
    check("rollover carry", int'(bus.day_carry), 1);
    check("rollover tens", int'(bus.hour_tens), 1 - 1 + ((`ifdef HOUR_12H_EN 1 `else 0 `endif)));
    check("rollover ones", int'(bus.hour_ones), `ifdef HOUR_12H_EN 2 `else 0 `endif);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("rollover carry gone", int'(bus.day_carry), 0);

    // display decoding at fixed hours
`ifdef HOUR_12H_EN
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    check("12h h0 tens", int'(bus.hour_tens), 1);
    check("12h h0 ones", int'(bus.hour_ones), 2);
    check("12h h0 pm", int'(bus.pm), 0);
    drive(0, 1, 13, 0, 0, 0, 0, 0);
    check("12h h13 tens", int'(bus.hour_tens), 0);
    check("12h h13 ones", int'(bus.hour_ones), 1);
    check("12h h13 pm", int'(bus.pm), 1);
    drive(0, 1, 12, 0, 0, 0, 0, 0);
    check("12h h12 tens", int'(bus.hour_tens), 1);
    check("12h h12 ones", int'(bus.hour_ones), 2);
    check("12h h12 pm", int'(bus.pm), 1);
    drive(0, 1, 23, 0, 0, 0, 0, 0);
    check("12h h23 tens", int'(bus.hour_tens), 1);
    check("12h h23 ones", int'(bus.hour_ones), 1);
    check("12h h23 hour", int'(bus.hour), 23);
`else
    drive(0, 1, 17, 0, 0, 0, 0, 0);
    check("bcd 17 tens", int'(bus.hour_tens), 1);
    check("bcd 17 ones", int'(bus.hour_ones), 7);
    drive(0, 1, 9, 0, 0, 0, 0, 0);
    check("bcd 9 tens", int'(bus.hour_tens), 0);
    check("bcd 9 ones", int'(bus.hour_ones), 9);
    drive(0, 1, 20, 0, 0, 0, 0, 0);
    check("bcd 20 tens", int'(bus.hour_tens), 2);
    check("bcd 20 ones", int'(bus.hour_ones), 0);
`endif

    // randomized run against the reference model
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check_all("rand start");
    sm = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) sm = 1 - sm;
      drive(($urandom_range(0, 99) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            int'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            sm,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            int'($urandom_range(0, 1)));
      check_all($sformatf("rand%0d", i));
    end

    bcd_exp(0, t, o);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
